imm_dec_stage: RTL and testbench
================================

Name: imm_dec_stage

Overview:
Decode-side pipeline stage that takes fetched RV64 instructions over a valid/ready handshake. Per instruction it:
- classifies the opcode into the team's immediate-select code;
- extracts the raw immediate fields and drives the immediate extender with them;
- registers the 64-bit immediate alongside the instruction and PC toward execute.

It holds a 2-entry skid buffer, so it sustains one instruction per cycle under backpressure. It supports a pipeline flush.

Parameters:
- PC_W, 64, width of the PC carried through the stage.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  input  1  stage clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept.
- in_inst  input  32  instruction word.
- in_pc  input  PC_W  instruction PC.
- out_valid  output  1  entry available downstream.
- out_ready  input  1  downstream accepts.
- out_inst  output  32  registered instruction.
- out_pc  output  PC_W  registered PC.
- out_imm  output  64  extended immediate.
- out_sel  output  4  immediate-select code used.
- out_illegal  output  1  opcode not recognised.

Behaviour:
- Select codes: 0 none, 1 I, 2 S, 3 B, 4 J, 5 U, 6 shamt. Opcode mapping:
  - 0000011 load, 1100111 JALR, 1110011 SYSTEM, 0011011 OP-IMM-32 with funct3 other than 001/101 → 1.
  - 0010011 OP-IMM: funct3 001/101 → 6, else → 1.
  - 0011011 with funct3 001/101 → 6; inst[25]=1 here additionally sets illegal.
  - 0100011 → 2. 1100011 → 3. 1101111 → 4. 0110111/0010111 → 5. 0110011/0111011 → 0.
  - Any other opcode → sel 0, illegal=1.
- Field extraction:
  - I = inst[31:20]; S = {inst[31:25],inst[11:7]}.
  - B = {inst[31],inst[7],inst[30:25],inst[11:8]}; J = {inst[31],inst[19:12],inst[20],inst[30:21]}; U = inst[31:12].
- Extension rules:
  - I/S: sign-extend 12→64.
  - B: sign-extend {B,0} (13 bits).
  - J: sign-extend {J,0} (21 bits).
  - U: sign-extend {U,12'b0} (32 bits).
  - shamt: zero-extend inst[25:20].
  - sel 0: imm = 0.
- Storage: main entry (feeds out_*) and skid entry. Each holds inst, pc, imm, sel, illegal, valid. Immediate is computed before registering; outputs come straight from the main entry, with no combinational path from in_* to out_*.
- Handshake: accept = in_valid & in_ready; fire = out_valid & out_ready. in_ready = !skid_valid (registered, never depends on out_ready).
- Latency: accepted instruction appears on out_* the next cycle when the main entry is empty or fires the same cycle.
- Accept while main is valid and not firing → entry goes to skid; in_ready drops the following cycle.
- Fire with skid valid → skid moves to main. A simultaneous accept lands in skid. Order is preserved strictly FIFO.
- out_* stay stable while out_valid & !out_ready.
- Flush: highest priority. Next cycle both valids = 0 and in_ready = 1. An accept in the flush cycle is discarded. A fire in the flush cycle still counts as delivered.
- Reset (async assert, sync-safe deassert): out_valid 0, in_ready 1, out_inst/out_pc/out_imm 0, out_sel 0, out_illegal 0, skid cleared. Reset mid-transfer drops all entries.

Optional Feature:
- Macro IMM_DEC_STAGE_PERF_EN.
- Defined: adds outputs perf_issued (CNT_W), the count of fires, and perf_stall (CNT_W), the count of cycles with out_valid & !out_ready.
  - Both clear on reset only (not flush) and wrap modulo 2^CNT_W.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- addi 0xFFF00093, out_ready=1 → next cycle out_valid=1, out_sel=1, out_imm=0xFFFFFFFFFFFFFFFF, out_illegal=0.
- beq 0xFE000EE3 → out_sel=3, out_imm=0xFFFFFFFFFFFFFFFC. jal 0x0000006F → out_sel=4, out_imm=0.
- slli 0x03F09093 → out_sel=6, out_imm=0x3F. lui 0x800000B7 → out_sel=5, out_imm=0xFFFFFFFF80000000.
- out_ready=0, three back-to-back valid instructions (PC 0x0/0x4/0x8):
  - two accepted; in_ready=0 from the cycle after the second accept;
  - raising out_ready delivers PCs 0x0, 0x4, then accepts and delivers 0x8; no loss or duplication.
- Both entries full, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears.
- 0x0000007F → out_illegal=1, out_sel=0, out_imm=0. Assert rst_n low mid-stream → out_valid=0 immediately, in_ready=1.

Source files
------------

// File: rtl/imm_dec_stage.sv
// Decode stage: immediate-select classification, RV64 immediate extension, 2-entry skid buffer.
// Optional perf counters (perf_issued, perf_stall) are enabled by defining IMM_DEC_STAGE_PERF_EN.
module imm_dec_stage #(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [PC_W-1:0] out_pc,
    output logic [63:0]     out_imm,
    output logic [3:0]      out_sel,
    output logic            out_illegal
`ifdef IMM_DEC_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_issued,
    output logic [CNT_W-1:0] perf_stall
`endif
);

    typedef enum logic [3:0] {
        SEL_NONE  = 4'd0,
        SEL_I     = 4'd1,
        SEL_S     = 4'd2,
        SEL_B     = 4'd3,
        SEL_J     = 4'd4,
        SEL_U     = 4'd5,
        SEL_SHAMT = 4'd6
    } sel_e;

    typedef struct packed {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
        logic [63:0]     imm;
        sel_e            sel;
        logic            illegal;
    } entry_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_shift;
    sel_e        dec_sel;
    logic        dec_illegal;
    logic [63:0] dec_imm;

    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic [11:0] imm_b;
    logic [19:0] imm_j;
    logic [19:0] imm_u;

    entry_t main_q;
    entry_t skid_q;
    entry_t new_entry;
    logic   main_valid;
    logic   skid_valid;
    logic   accept;
    logic   fire;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // NOTE: defaults are assigned first so every path through the case drives both outputs (no latch).
    always_comb begin
        dec_sel     = SEL_NONE;
        dec_illegal = 1'b0;
        unique case (opcode)
            7'b0000011, 7'b1100111, 7'b1110011: dec_sel = SEL_I;
            7'b0010011: dec_sel = is_shift ? SEL_SHAMT : SEL_I;
            7'b0011011: begin
                dec_sel     = is_shift ? SEL_SHAMT : SEL_I;
                dec_illegal = is_shift & in_inst[25];
            end
            7'b0100011:             dec_sel = SEL_S;
            7'b1100011:             dec_sel = SEL_B;
            7'b1101111:             dec_sel = SEL_J;
            7'b0110111, 7'b0010111: dec_sel = SEL_U;
            7'b0110011, 7'b0111011: dec_sel = SEL_NONE;
            default:                dec_illegal = 1'b1;
        endcase
    end

    assign imm_i = in_inst[31:20];
    assign imm_s = {in_inst[31:25], in_inst[11:7]};
    assign imm_b = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8]};
    assign imm_j = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21]};
    assign imm_u = in_inst[31:12];

    always_comb begin
        dec_imm = 64'd0;
        unique case (dec_sel)
            SEL_I:     dec_imm = {{52{imm_i[11]}}, imm_i};
            SEL_S:     dec_imm = {{52{imm_s[11]}}, imm_s};
            SEL_B:     dec_imm = {{51{imm_b[11]}}, imm_b, 1'b0};
            SEL_J:     dec_imm = {{43{imm_j[19]}}, imm_j, 1'b0};
            SEL_U:     dec_imm = {{32{imm_u[19]}}, imm_u, 12'd0};
            SEL_SHAMT: dec_imm = {58'd0, in_inst[25:20]};
            default:   dec_imm = 64'd0;
        endcase
    end

    assign new_entry = '{inst: in_inst, pc: in_pc, imm: dec_imm, sel: dec_sel, illegal: dec_illegal};

    // in_ready depends only on registered state, so accept never implies a full skid entry.
    assign in_ready = !skid_valid;
    assign accept   = in_valid & in_ready;
    assign fire     = main_valid & out_ready;

    // NOTE: payload registers are reset as well so out_* read zero after reset instead of stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || fire) begin
            // NOTE: non-blocking assignments so each register samples pre-edge values.
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) main_q <= new_entry;
            end
        end else if (accept) begin
            skid_q     <= new_entry;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid   = main_valid;
    assign out_inst    = main_q.inst;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_sel     = main_q.sel;
    assign out_illegal = main_q.illegal;

`ifdef IMM_DEC_STAGE_PERF_EN
    // Counters survive flush; only reset clears them, and they wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (fire) perf_issued <= perf_issued + 1'b1;
            if (main_valid && !out_ready) perf_stall <= perf_stall + 1'b1;
        end
    end
`else
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
`endif

endmodule

// File: tb/tb_imm_dec_stage.sv
// Self-checking bench for imm_dec_stage: vector table, directed handshake/flush/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_imm_dec_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic [63:0] out_imm;
    logic [3:0]  out_sel;
    logic        out_illegal;
`ifdef IMM_DEC_STAGE_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    int total = 0;
    int bad   = 0;

    imm_dec_stage #(.PC_W(64), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_imm    (out_imm),
        .out_sel    (out_sel),
        .out_illegal(out_illegal)
`ifdef IMM_DEC_STAGE_PERF_EN
        ,
        .perf_issued(perf_issued),
        .perf_stall (perf_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] inst;
        logic [3:0]  sel;
        logic [63:0] imm;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [3:0]  sel;
        logic        ill;
    } exp_t;

    vec_t vecs[14];
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decoder built from the field rules with integer arithmetic.
    function automatic void ref_dec(input logic [31:0] i, output logic [3:0] s,
                                    output logic [63:0] m, output logic il);
        longint v;
        bit sh;
        sh = (i[14:12] == 3'd1) || (i[14:12] == 3'd5);
        il = 1'b0;
        s  = 4'd0;
        v  = 0;
        case (i[6:0])
            7'h03, 7'h67, 7'h73: s = 4'd1;
            7'h13: s = sh ? 4'd6 : 4'd1;
            7'h1B: begin s = sh ? 4'd6 : 4'd1; il = sh && i[25]; end
            7'h23: s = 4'd2;
            7'h63: s = 4'd3;
            7'h6F: s = 4'd4;
            7'h37, 7'h17: s = 4'd5;
            7'h33, 7'h3B: s = 4'd0;
            default: il = 1'b1;
        endcase
        case (s)
            4'd1: begin v = longint'(i[31:20]); if (v >= 2048) v = v - 4096; end
            4'd2: begin
                v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
                if (v >= 2048) v = v - 4096;
            end
            4'd3: begin
                v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                  + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
                if (i[31]) v = v - 8192;
            end
            4'd4: begin
                v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096
                  + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
                if (i[31]) v = v - 2097152;
            end
            4'd5: begin
                v = longint'(i[31:12]) * 4096;
                if (i[31]) v = v - 64'sh1_0000_0000;
            end
            4'd6: v = longint'(i[25:20]);
            default: v = 0;
        endcase
        m = 64'(v);
    endfunction

    logic [6:0] ops[15] = '{7'h03, 7'h67, 7'h73, 7'h13, 7'h1B, 7'h1B, 7'h23, 7'h63,
                            7'h6F, 7'h37, 7'h17, 7'h33, 7'h3B, 7'h7F, 7'h0B};

    initial begin
        logic [31:0] r;
        logic [3:0]  es;
        logic [63:0] em;
        logic        ei;
        bit          acc;
        bit          fir;

        vecs[0]  = '{32'hFFF00093, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0}; // addi -1
        vecs[1]  = '{32'hFE000EE3, 4'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0}; // beq -4
        vecs[2]  = '{32'h0000006F, 4'd4, 64'h0, 1'b0};                   // jal 0
        vecs[3]  = '{32'h03F09093, 4'd6, 64'h3F, 1'b0};                  // slli 63
        vecs[4]  = '{32'h800000B7, 4'd5, 64'hFFFF_FFFF_8000_0000, 1'b0}; // lui
        vecs[5]  = '{32'h0000007F, 4'd0, 64'h0, 1'b1};                   // unknown opcode
        vecs[6]  = '{{7'h7F, 5'd2, 5'd1, 3'b010, 5'b11000, 7'b0100011}, 4'd2,
                     64'hFFFF_FFFF_FFFF_FFF8, 1'b0};                     // sw -8
        vecs[7]  = '{32'h002081B3, 4'd0, 64'h0, 1'b0};                   // add
        vecs[8]  = '{32'h00001017, 4'd5, 64'h1000, 1'b0};                // auipc
        vecs[9]  = '{32'h7FF13083, 4'd1, 64'h7FF, 1'b0};                 // ld +2047
        vecs[10] = '{32'h8000006F, 4'd4, 64'hFFFF_FFFF_FFF0_0000, 1'b0}; // jal min
        vecs[11] = '{32'h8000001B, 4'd1, 64'hFFFF_FFFF_FFFF_F800, 1'b0}; // addiw -2048
        vecs[12] = '{{7'b0000001, 5'd1, 5'd1, 3'b001, 5'd1, 7'b0011011}, 4'd6,
                     64'h21, 1'b1};                                      // slliw bit25 set
        vecs[13] = '{32'h00008067, 4'd1, 64'h0, 1'b0};                   // jalr ret

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_imm", out_imm, 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_out_sel", 64'(out_sel), 64'd0);
        check("rst_out_illegal", 64'(out_illegal), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Vector table, streaming one per cycle with out_ready high.
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            in_pc    = 64'h1000 + 64'(i * 4);
            step();
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_inst", i), 64'(out_inst), 64'(vecs[i].inst));
            check($sformatf("vec%0d_pc", i), out_pc, 64'h1000 + 64'(i * 4));
            check($sformatf("vec%0d_sel", i), 64'(out_sel), 64'(vecs[i].sel));
            check($sformatf("vec%0d_imm", i), out_imm, vecs[i].imm);
            check($sformatf("vec%0d_ill", i), 64'(out_illegal), 64'(vecs[i].ill));
        end
        in_valid = 1'b0;
        step();
        check("vec_drain_valid", 64'(out_valid), 64'd0);

        // Backpressure: three back-to-back instructions against a stalled consumer.
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF00093;
        in_pc = 64'h0; step();
        check("bp_first_valid", 64'(out_valid), 64'd1);
        check("bp_first_pc", out_pc, 64'h0);
        check("bp_ready_after1", 64'(in_ready), 64'd1);
        in_pc = 64'h4; step();
        check("bp_ready_after2", 64'(in_ready), 64'd0);
        check("bp_hold_pc", out_pc, 64'h0);
        in_pc = 64'h8; step();
        check("bp_still_full", 64'(in_ready), 64'd0);
        check("bp_stable_pc", out_pc, 64'h0);
        out_ready = 1'b1; step();
        check("bp_deliver4", out_pc, 64'h4);
        check("bp_ready_again", 64'(in_ready), 64'd1);
        step();
        check("bp_deliver8_valid", 64'(out_valid), 64'd1);
        check("bp_deliver8", out_pc, 64'h8);
        in_valid = 1'b0; step();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Flush with both entries full and an offered input.
        out_ready = 1'b0; in_valid = 1'b1;
        in_pc = 64'h100; step();
        in_pc = 64'h104; step();
        check("fl_full", 64'(in_ready), 64'd0);
        flush = 1'b1; in_pc = 64'h200; step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1; step();
        check("fl_no_ghost", 64'(out_valid), 64'd0);

        // Flush while an accept and a fire coincide: the accept is dropped.
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h300; step();
        check("fl2_main", out_pc, 64'h300);
        flush = 1'b1; out_ready = 1'b1; in_pc = 64'h304; step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl2_valid", 64'(out_valid), 64'd0);
        check("fl2_ready", 64'(in_ready), 64'd1);
        step();
        check("fl2_no_ghost", 64'(out_valid), 64'd0);

        // Randomized traffic against the queue model.
        for (int c = 0; c < 600; c++) begin
            r = $urandom();
            in_inst   = {r[31:7], ops[$urandom_range(0, 14)]};
            in_pc     = {32'($urandom()), 32'($urandom())};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            #1;
            check("rnd_in_ready", 64'(in_ready), 64'(sb.size() < 2));
            check("rnd_out_valid", 64'(out_valid), 64'(sb.size() > 0));
            acc = in_valid && (sb.size() < 2);
            fir = out_ready && (sb.size() > 0);
            if (fir) begin
                check("rnd_inst", 64'(out_inst), 64'(sb[0].inst));
                check("rnd_pc", out_pc, sb[0].pc);
                check("rnd_imm", out_imm, sb[0].imm);
                check("rnd_sel", 64'(out_sel), 64'(sb[0].sel));
                check("rnd_ill", 64'(out_illegal), 64'(sb[0].ill));
                void'(sb.pop_front());
            end
            if (flush) begin
                sb.delete();
            end else if (acc) begin
                ref_dec(in_inst, es, em, ei);
                sb.push_back('{in_inst, in_pc, em, es, ei});
            end
            step();
        end
        flush = 1'b0;

        // Asynchronous reset while both entries are occupied.
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h800000B7;
        in_pc = 64'h500; step();
        in_pc = 64'h504; step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd1);
        check("arst_pc", out_pc, 64'd0);
        check("arst_imm", out_imm, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("arst_dropped", 64'(out_valid), 64'd0);
        step();
        check("arst_still_empty", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
